// File: rtl/user_req_buffer_pkg.sv
// Shared types and frame-layout helpers for the user request buffer.
package user_req_buffer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Frame word is {done, id, data}; these give the field positions.
  function automatic int unsigned done_bit(input int unsigned id_w, input int unsigned data_w);
    return id_w + data_w;
  endfunction

  function automatic int unsigned id_lsb(input int unsigned data_w);
    return data_w;
  endfunction

endpackage

// File: rtl/user_req_buffer_if.sv
// Load / authentication / write-back bus of the user request buffer.
interface user_req_buffer_if #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ID_W   = 7,
  parameter int unsigned DATA_W = 8
);
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned FW     = 1 + ID_W + DATA_W;

  logic              load;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic [ID_W-1:0]   id;
  logic              load_ready;
  logic              auth_done;
  logic              auth_fail;
  logic              start;
  logic [FW-1:0]     frame;
  logic [DATA_W-1:0] wb_data;
  logic              wb_valid;
  logic              wb_ready;
  logic [ADDR_W:0]   pend_count;
  logic [ADDR_W:0]   wb_count;
  logic              err_ovf;
  logic              err_auth;

  modport master (
    output load, addr, data_in, id, auth_done, auth_fail, wb_data, wb_valid,
    input  load_ready, start, frame, wb_ready, pend_count, wb_count, err_ovf, err_auth
  );

  modport slave (
    input  load, addr, data_in, id, auth_done, auth_fail, wb_data, wb_valid,
    output load_ready, start, frame, wb_ready, pend_count, wb_count, err_ovf, err_auth
  );

endinterface

// File: rtl/user_req_buffer_addr_fifo.sv
// Circular FIFO of slot addresses; callers never push when full or pop when empty.
module addr_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] dout,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  logic [ADDR_W-1:0] slot_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + (ADDR_W+1)'(1);
    else if (pop && !push) count_d = count_q - (ADDR_W+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) slot_q[wr_ptr_q] <= din;
  end

  assign dout  = slot_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == (ADDR_W+1)'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/user_req_buffer.sv
// User request buffer: slot memory, pending/write-back address queues and send FSM.
module user_req_buffer
  import user_req_buffer_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = $clog2(DEPTH),
  parameter int unsigned ID_W   = 7,
  parameter int unsigned DATA_W = 8
) (
  input logic              clk,
  input logic              rst,
  user_req_buffer_if.slave bus
);

  localparam int unsigned FW = 1 + ID_W + DATA_W;
  localparam int unsigned DB = done_bit(ID_W, DATA_W);
  localparam int unsigned IL = id_lsb(DATA_W);

  logic [FW-1:0]     mem_q [DEPTH];
  state_e            state_q, state_d;
  logic [FW-1:0]     frame_q, frame_d;
  logic              err_ovf_q, err_ovf_d;
  logic              err_auth_q, err_auth_d;

  logic [ADDR_W-1:0] pend_head, wb_head;
  logic [ADDR_W:0]   pend_cnt, wb_cnt;
  logic              pend_full, pend_empty, wb_full, wb_empty;
  logic              load_ok, auth_ok, auth_bad, wb_fire;

  assign load_ok  = bus.load && !pend_full;
  assign auth_ok  = (state_q == SEND) && (bus.auth_done ^ bus.auth_fail);
  assign auth_bad = (bus.auth_done || bus.auth_fail) &&
                    ((state_q == IDLE) || (bus.auth_done && bus.auth_fail));
  assign wb_fire  = bus.wb_valid && !wb_empty && !bus.load;

  addr_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_pend (
    .clk(clk), .rst(rst), .push(load_ok), .pop(auth_ok), .din(bus.addr),
    .dout(pend_head), .count(pend_cnt), .full(pend_full), .empty(pend_empty)
  );

  addr_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_wb (
    .clk(clk), .rst(rst), .push(auth_ok && bus.auth_done), .pop(wb_fire), .din(pend_head),
    .dout(wb_head), .count(wb_cnt), .full(wb_full), .empty(wb_empty)
  );

  // Load owns the single write port; write-back keeps the stored id and sets done.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (load_ok) begin
      mem_q[bus.addr] <= {1'b0, bus.id, bus.data_in};
    end else if (wb_fire) begin
      mem_q[wb_head] <= {1'b1, mem_q[wb_head][DB-1:IL], bus.wb_data};
    end
  end

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    err_ovf_d  = err_ovf_q | (bus.load && pend_full);
    err_auth_d = err_auth_q | auth_bad;
    case (state_q)
      IDLE: if (!pend_empty && !wb_full) begin
        state_d = SEND;
        frame_d = mem_q[pend_head];
      end
      SEND: if (auth_ok) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      frame_q    <= '0;
      err_ovf_q  <= 1'b0;
      err_auth_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      err_ovf_q  <= err_ovf_d;
      err_auth_q <= err_auth_d;
    end
  end

  assign bus.load_ready = !pend_full;
  assign bus.wb_ready   = !wb_empty && !bus.load;
  assign bus.start      = (state_q == SEND);
  assign bus.frame      = frame_q;
  assign bus.pend_count = pend_cnt;
  assign bus.wb_count   = wb_cnt;
  assign bus.err_ovf    = err_ovf_q;
  assign bus.err_auth   = err_auth_q;

endmodule

// File: tb/tb_user_req_buffer.sv
// Directed + random bench for user_req_buffer against a queue-based reference model.
module tb_user_req_buffer;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ID_W   = 7;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned FW     = 1 + ID_W + DATA_W;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  user_req_buffer_if #(.DEPTH(DEPTH), .ID_W(ID_W), .DATA_W(DATA_W)) bus ();

  user_req_buffer #(.DEPTH(DEPTH), .ID_W(ID_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  // Reference model: slot array plus address queues.
  logic [FW-1:0] m_mem [DEPTH];
  int unsigned   pq[$];
  int unsigned   wq[$];
  bit            m_send;
  logic [FW-1:0] m_frame;
  bit            m_ovf, m_eauth;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("start",      32'(bus.start),      32'(m_send));
    check("frame",      32'(bus.frame),      32'(m_frame));
    check("pend_count", 32'(bus.pend_count), pq.size());
    check("wb_count",   32'(bus.wb_count),   wq.size());
    check("err_ovf",    32'(bus.err_ovf),    32'(m_ovf));
    check("err_auth",   32'(bus.err_auth),   32'(m_eauth));
  endtask

  task automatic check_mem();
    for (int k = 0; k < int'(DEPTH); k++)
      check($sformatf("mem[%0d]", k), 32'(dut.mem_q[k]), 32'(m_mem[k]));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.load = 0; bus.addr = '0; bus.id = '0; bus.data_in = '0;
    bus.auth_done = 0; bus.auth_fail = 0; bus.wb_valid = 0; bus.wb_data = '0;
    @(posedge clk);
    for (int k = 0; k < int'(DEPTH); k++) m_mem[k] = '0;
    pq.delete(); wq.delete();
    m_send = 0; m_frame = '0; m_ovf = 0; m_eauth = 0;
    #1;
    rst = 1'b0;
    check_outputs();
    check_mem();
  endtask

  task automatic step(input bit ld, input logic [3:0] a, input logic [6:0] i, input logic [7:0] d,
                      input bit ad, input bit af, input bit wv, input logic [7:0] wd);
    bit            rdy, wbr, enter;
    logic [FW-1:0] snap;
    int unsigned   ph, wh;
    bus.load = ld; bus.addr = a; bus.id = i; bus.data_in = d;
    bus.auth_done = ad; bus.auth_fail = af; bus.wb_valid = wv; bus.wb_data = wd;
    #1;
    rdy = pq.size() < DEPTH;
    wbr = (wq.size() > 0) && !ld;
    check("load_ready", 32'(bus.load_ready), 32'(rdy));
    check("wb_ready",   32'(bus.wb_ready),   32'(wbr));
    @(posedge clk);
    enter = !m_send && (pq.size() > 0) && (wq.size() < DEPTH);
    snap  = enter ? m_mem[pq[0]] : '0;
    if (ld && !rdy) m_ovf = 1;
    if ((ad || af) && (!m_send || (ad && af))) m_eauth = 1;
    if (ld && rdy) m_mem[a] = {1'b0, i, d};
    else if (wv && wbr) begin
      wh = wq.pop_front();
      m_mem[wh] = {1'b1, m_mem[wh][14:8], wd};
    end
    if (m_send && (ad ^ af)) begin
      ph = pq.pop_front();
      if (ad) wq.push_back(ph);
      m_send = 0;
    end else if (enter) begin
      m_send  = 1;
      m_frame = snap;
    end
    if (ld && rdy) pq.push_back(a);
    #1;
    check_outputs();
  endtask

  task automatic idle();
    step(0, '0, '0, '0, 0, 0, 0, '0);
  endtask

  initial begin
    int guard;
    do_reset();

    // Single request through auth and write-back.
    step(1, 4'd3, 7'h15, 8'hA7, 0, 0, 0, '0);
    check("single_no_start_yet", 32'(bus.start), 32'd0);
    idle();
    check("single_frame", 32'(bus.frame), 32'h15A7);
    step(0, '0, '0, '0, 1, 0, 0, '0);
    check("single_wb_count", 32'(bus.wb_count), 32'd1);
    step(0, '0, '0, '0, 0, 0, 1, 8'h3C);
    check("single_mem3", 32'(dut.mem_q[3]), 32'h953C);

    // Auth fail drops the address and leaves the slot alone.
    step(1, 4'd5, 7'h02, 8'h11, 0, 0, 0, '0);
    idle();
    step(0, '0, '0, '0, 0, 1, 0, '0);
    step(0, '0, '0, '0, 0, 0, 1, 8'h77);
    check("fail_mem5", 32'(dut.mem_q[5]), 32'h0211);
    check_mem();

    // Pending overflow, then write-back queue full stall.
    do_reset();
    for (int k = 0; k < 16; k++) step(1, 4'(k), 7'(k + 1), 8'(k * 3), 0, 0, 0, '0);
    check("ovf_not_ready", 32'(bus.load_ready), 32'd0);
    step(1, 4'd3, 7'h7F, 8'hEE, 0, 0, 0, '0);
    check("ovf_flag", 32'(bus.err_ovf), 32'd1);
    check_mem();
    guard = 0;
    while (wq.size() < DEPTH && guard < 100) begin
      if (m_send) step(0, '0, '0, '0, 1, 0, 0, '0);
      else idle();
      guard++;
    end
    check("wbfill_bound", 32'(wq.size()), DEPTH);
    step(1, 4'd9, 7'h33, 8'h44, 0, 0, 0, '0);
    repeat (3) idle();
    check("wbfull_start_hold", 32'(bus.start), 32'd0);
    step(0, '0, '0, '0, 0, 0, 1, 8'h5A);
    idle();
    check("wbfull_start_after", 32'(bus.start), 32'd1);

    // Load and write-back offered together: load wins.
    step(1, 4'd1, 7'h0A, 8'hB0, 0, 0, 1, 8'hC1);
    step(0, '0, '0, '0, 0, 0, 1, 8'hC2);
    check_mem();

    // Protocol errors and reset during SEND.
    do_reset();
    step(0, '0, '0, '0, 1, 0, 0, '0);
    check("auth_in_idle", 32'(bus.err_auth), 32'd1);
    step(1, 4'd7, 7'h11, 8'h22, 0, 0, 0, '0);
    idle();
    step(0, '0, '0, '0, 1, 1, 0, '0);
    check("both_auth_hold", 32'(bus.start), 32'd1);
    do_reset();
    check("reset_start", 32'(bus.start), 32'd0);

    // Load/auth/write-back sequences exercising pointer wrap.
    for (int n = 0; n < 40; n++) begin
      step(1, 4'($urandom), 7'($urandom), 8'($urandom), 0, 0, 0, '0);
      guard = 0;
      while (!m_send && guard < 8) begin idle(); guard++; end
      step(0, '0, '0, '0, 1, 0, 0, '0);
      step(0, '0, '0, '0, 0, 0, 1, 8'($urandom));
    end
    check("seq_pend_zero", 32'(bus.pend_count), 32'd0);
    check("seq_wb_zero",   32'(bus.wb_count),   32'd0);
    check_mem();

    // Random mix, then drain.
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 2) == 0, 4'($urandom), 7'($urandom), 8'($urandom),
           m_send ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0),
           $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1, 8'($urandom));
    end
    guard = 0;
    while ((pq.size() > 0 || wq.size() > 0) && guard < 200) begin
      step(0, '0, '0, '0, m_send, 0, 1, 8'($urandom));
      guard++;
    end
    check("drain_pend_zero", 32'(bus.pend_count), 32'd0);
    check("drain_wb_zero",   32'(bus.wb_count),   32'd0);
    check_mem();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
